// File: rtl/az_bus_if.sv
// CPU-side bus interface: zero-wait scratchpad (SPM) decode plus a single-outstanding
// request/grant/ready external bus master with optional access timeout.
module az_bus_if #(
    parameter int unsigned           DATA_W     = 32,
    parameter int unsigned           ADDR_W     = 30,
    parameter int unsigned           SPM_TAG_W  = 16,
    parameter logic [SPM_TAG_W-1:0]  SPM_TAG    = '0,
    parameter int unsigned           SPM_ADDR_W = 12,
    parameter int unsigned           TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU side
    input  logic                  cpu_as,
    input  logic                  cpu_rw,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wr_data,
    output logic [DATA_W-1:0]     cpu_rd_data,
    output logic                  busy,
    output logic                  err,
    input  logic                  stall,
    input  logic                  flush,
    // Scratchpad memory
    output logic                  spm_as_,
    output logic                  spm_rw,
    output logic [SPM_ADDR_W-1:0] spm_addr,
    output logic [DATA_W-1:0]     spm_wr_data,
    input  logic [DATA_W-1:0]     spm_rd_data,
    // External bus
    output logic                  bus_reqn,
    input  logic                  bus_grntn,
    output logic                  bus_asn,
    output logic                  bus_rwn,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wr_data,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_rdyn
);

    localparam int unsigned    CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StReq, StAccess, StStall} state_e;

    state_e              state_q, state_d;
    logic                bus_reqn_q, bus_reqn_d;
    logic                bus_asn_q, bus_asn_d;
    logic                bus_rwn_q, bus_rwn_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
    logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
    logic [CntW-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic spm_hit;
    logic tmo_hit;

    assign spm_hit = (cpu_addr[ADDR_W-1 -: SPM_TAG_W] == SPM_TAG);
    // tmo_cnt_q counts prior unready ACCESS cycles, so this fires on ACCESS cycle TIMEOUT
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TmoLast);

    // SPM data/address follow the CPU unconditionally; only the strobe is qualified
    assign spm_rw      = cpu_rw;
    assign spm_addr    = cpu_addr[SPM_ADDR_W-1:0];
    assign spm_wr_data = cpu_wr_data;

    assign bus_reqn    = bus_reqn_q;
    assign bus_asn     = bus_asn_q;
    assign bus_rwn     = bus_rwn_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;

    always_comb begin
        state_d       = state_q;
        bus_reqn_d    = bus_reqn_q;
        bus_asn_d     = bus_asn_q;
        bus_rwn_d     = bus_rwn_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_buf_d      = rd_buf_q;
        tmo_cnt_d     = tmo_cnt_q;
        spm_as_       = 1'b1;
        cpu_rd_data   = '0;
        busy          = 1'b0;
        err           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_as && !flush) begin
                    if (spm_hit) begin
                        spm_as_     = 1'b0;
                        cpu_rd_data = spm_rd_data;
                    end else begin
                        busy          = 1'b1;
                        bus_reqn_d    = 1'b0;
                        bus_rwn_d     = cpu_rw;
                        bus_addr_d    = cpu_addr;
                        bus_wr_data_d = cpu_wr_data;
                        state_d       = StReq;
                    end
                end
            end
            StReq: begin
                busy = 1'b1;
                if (!bus_grntn) begin
                    bus_asn_d = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                bus_asn_d = 1'b1;
                if (!bus_rdyn) begin
                    // Completion has priority over a coincident timeout
                    cpu_rd_data = bus_rwn_q ? bus_rdata : '0;
                    bus_reqn_d  = 1'b1;
                    if (bus_rwn_q) begin
                        rd_buf_d = bus_rdata;
                    end
                    state_d = stall ? StStall : StIdle;
                end else if (tmo_hit) begin
                    err        = 1'b1;
                    bus_reqn_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    busy      = 1'b1;
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StStall: begin
                cpu_rd_data = rd_buf_q;
                if (!stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            bus_reqn_q    <= 1'b1;
            bus_asn_q     <= 1'b1;
            bus_rwn_q     <= 1'b1;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_buf_q      <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            bus_reqn_q    <= bus_reqn_d;
            bus_asn_q     <= bus_asn_d;
            bus_rwn_q     <= bus_rwn_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_buf_q      <= rd_buf_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

endmodule
